nor_gate_bank: RTL

Parametrised bank of CHANNELS independent INPUTS-input NOR gates for the AGC logic simulation, succeeding the fixed three-gate 3-input chip models. Each channel has a per-channel reset value, a clocked propagation delay of DELAY cycles in either transport or inertial mode, and a toggle-rate monitor. The monitor flags oscillating feedback loops, such as mis-initialised latches or ring paths, that the fixed-count chip models cannot detect. Chip models and generated backplane netlists instantiate it wherever NOR logic is needed.

---
 rtl/nor_gate_bank.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/nor_gate_bank.sv
// Bank of independent multi-input NOR gates with a per-channel clocked delay
// (transport or inertial) and a sticky toggle-rate oscillation monitor.
module nor_gate_bank #(
  parameter int unsigned         CHANNELS    = 3,
  parameter int unsigned         INPUTS      = 3,
  parameter int unsigned         DELAY       = 9,
  parameter logic [CHANNELS-1:0] IC          = '0,
  parameter int unsigned         INERTIAL    = 0,
  parameter int unsigned         WINDOW      = 64,
  parameter int unsigned         MAX_TOGGLES = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS*INPUTS-1:0]   in,
  input  logic                         osc_clr,
  output logic [CHANNELS-1:0]          y,
  output logic [CHANNELS-1:0]          osc,
  output logic                         osc_any
);

  localparam int unsigned CNT_W = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam int unsigned WC_W  = $clog2(WINDOW);
  localparam int unsigned TC_W  = $clog2(MAX_TOGGLES + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY - 1);
  localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(WINDOW - 1);
  localparam logic [TC_W-1:0]  TC_MAX   = TC_W'(MAX_TOGGLES);

  logic [CHANNELS-1:0] n;
  logic [CHANNELS-1:0] y_now;
  logic [CHANNELS-1:0] y_next;

  always_comb begin
    n = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      n[i] = ~|in[i*INPUTS +: INPUTS];
    end
  end

  generate
    if (INERTIAL != 0) begin : g_inertial
      logic [CHANNELS-1:0] y_q;
      logic [CHANNELS-1:0] y_d;
      logic [CNT_W-1:0]    cnt_q [CHANNELS];
      logic [CNT_W-1:0]    cnt_d [CHANNELS];

      // cnt counts consecutive edges at which n disagrees with y
      always_comb begin
        y_d   = y_q;
        cnt_d = cnt_q;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          if (n[i] == y_q[i]) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            y_d[i]   = n[i];
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          y_q   <= IC;
          cnt_q <= '{default: '0};
        end else begin
          y_q   <= y_d;
          cnt_q <= cnt_d;
        end
      end

      always_comb begin
        y_now  = y_q;
        y_next = y_d;
      end
    end else begin : g_transport
      logic [DELAY-1:0] sr_q [CHANNELS];
      logic [DELAY-1:0] sr_d [CHANNELS];

      // Stage 0 is the LSB; the MSB is the delayed output
      always_comb begin
        y_now  = '0;
        y_next = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          sr_d[i]   = (sr_q[i] << 1) | DELAY'(n[i]);
          y_now[i]  = sr_q[i][DELAY-1];
          y_next[i] = sr_d[i][DELAY-1];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int unsigned i = 0; i < CHANNELS; i++) begin
            sr_q[i] <= {DELAY{IC[i]}};
          end
        end else begin
          sr_q <= sr_d;
        end
      end
    end
  endgenerate

  logic [WC_W-1:0]     wc_q, wc_d;
  logic [TC_W-1:0]     tc_q [CHANNELS];
  logic [TC_W-1:0]     tc_d [CHANNELS];
  logic [CHANNELS-1:0] osc_q, osc_d;
  logic [CHANNELS-1:0] toggle;
  logic                wrap;

  // The oscillation check uses the pre-wrap count; a wrap-edge toggle opens the new window at 1
  always_comb begin
    wrap   = (wc_q == WC_LAST);
    wc_d   = wrap ? '0 : wc_q + WC_W'(1);
    toggle = y_next ^ y_now;
    osc_d  = '0;
    tc_d   = tc_q;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      osc_d[i] = (toggle[i] && (tc_q[i] == TC_MAX)) || (osc_q[i] && !osc_clr);
      if (wrap) begin
        tc_d[i] = toggle[i] ? TC_W'(1) : '0;
      end else if (toggle[i] && (tc_q[i] != TC_MAX)) begin
        tc_d[i] = tc_q[i] + TC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wc_q  <= '0;
      tc_q  <= '{default: '0};
      osc_q <= '0;
    end else begin
      wc_q  <= wc_d;
      tc_q  <= tc_d;
      osc_q <= osc_d;
    end
  end

  assign y       = y_now;
  assign osc     = osc_q;
  assign osc_any = |osc_q;

endmodule
